// File: rtl/fibo_pkg.sv
// Shared encodings for the Fibonacci sequencer and the ALU it drives.
package fibo_pkg;

    localparam logic [2:0] FN_PASSX = 3'b000;
    localparam logic [2:0] FN_PASSY = 3'b001;
    localparam logic [2:0] FN_ONE   = 3'b010;
    localparam logic [2:0] FN_DEC   = 3'b011;
    localparam logic [2:0] FN_ADD   = 3'b100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DEC   = 3'd5,
        DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/fibo_ctrl.sv
// Fibonacci sequencer: one ALU op per cycle, done at 3+4n cycles after start acceptance.
// No backpressure; start is sampled only in IDLE and ignored otherwise.
module fibo_ctrl
    import fibo_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] n_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [2:0]       alu_fn,
    output logic [WIDTH-1:0] alu_x,
    output logic [WIDTH-1:0] alu_y,
    input  logic [WIDTH-1:0] alu_z
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, t_q, t_d, cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             a_wrap_q, a_wrap_d, b_wrap_q, b_wrap_d, t_wrap_q, t_wrap_d;
    logic             ovf_q, ovf_d, busy_q, busy_d, done_q, done_d;

    // ALU drive is decoded from the current state so alu_z is usable in the same cycle.
    always_comb begin
        alu_fn = FN_PASSX;
        alu_x  = '0;
        alu_y  = '0;
        unique case (state_q)
            INIT:    alu_fn = FN_ONE;
            CHECK:   alu_x  = cnt_q;
            ADD: begin
                alu_fn = FN_ADD;
                alu_x  = a_q;
                alu_y  = b_q;
            end
            SHIFT:   alu_x  = b_q;
            DEC: begin
                alu_fn = FN_DEC;
                alu_x  = cnt_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        t_d      = t_q;
        cnt_d    = cnt_q;
        a_wrap_d = a_wrap_q;
        b_wrap_d = b_wrap_q;
        t_wrap_d = t_wrap_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d    = n_in;
                    a_d      = '0;
                    a_wrap_d = 1'b0;
                    b_wrap_d = 1'b0;
                    state_d  = INIT;
                end
            end
            INIT: begin
                b_d     = alu_z;
                state_d = CHECK;
            end
            CHECK:   state_d = (cnt_q == '0) ? DONE : ADD;
            ADD: begin
                t_d      = alu_z;
                t_wrap_d = (alu_z < a_q) | a_wrap_q | b_wrap_q;
                state_d  = SHIFT;
            end
            SHIFT: begin
                a_d      = alu_z;
                b_d      = t_q;
                a_wrap_d = b_wrap_q;
                b_wrap_d = t_wrap_q;
                state_d  = DEC;
            end
            DEC: begin
                cnt_d   = alu_z;
                state_d = CHECK;
            end
            DONE: begin
                result_d = a_q;
                ovf_d    = a_wrap_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            t_q      <= '0;
            cnt_q    <= '0;
            a_wrap_q <= 1'b0;
            b_wrap_q <= 1'b0;
            t_wrap_q <= 1'b0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            t_q      <= t_d;
            cnt_q    <= cnt_d;
            a_wrap_q <= a_wrap_d;
            b_wrap_q <= b_wrap_d;
            t_wrap_q <= t_wrap_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule
